// File: rtl/lab3b_sweep_ctrl.sv
// Exhaustive sweep sequencer for the Lab 3b nine-input function. It steps a shared vector
// through every minterm, counts A's ones and A/B disagreements, and captures the first mismatch.
module lab3b_sweep_ctrl #(
  parameter int unsigned N_IN = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            a_out,
  input  logic            b_out,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_count,
  output logic [N_IN:0]   mismatch_count,
  output logic            mismatch_found,
  output logic [N_IN-1:0] first_mismatch
);

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } state_e;

  localparam logic [N_IN-1:0] VecLast = '1;
  localparam logic [N_IN-1:0] VecOne  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CntOne  = {{N_IN{1'b0}}, 1'b1};

  state_e          r_state, w_state;
  logic [N_IN-1:0] r_vec, w_vec;
  logic [N_IN:0]   r_ones, w_ones;
  logic [N_IN:0]   r_mm, w_mm;
  logic            r_found, w_found;
  logic [N_IN-1:0] r_first, w_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_vec   <= '0;
      r_ones  <= '0;
      r_mm    <= '0;
      r_found <= 1'b0;
      r_first <= '0;
    end else begin
      r_state <= w_state;
      r_vec   <= w_vec;
      r_ones  <= w_ones;
      r_mm    <= w_mm;
      r_found <= w_found;
      r_first <= w_first;
    end
  end

  always_comb begin
    w_state = r_state;
    w_vec   = r_vec;
    w_ones  = r_ones;
    w_mm    = r_mm;
    w_found = r_found;
    w_first = r_first;
    unique case (r_state)
      StIdle: begin
        // start together with abort is treated as no request
        if (start && !abort) begin
          w_state = StSweep;
          w_vec   = '0;
          w_ones  = '0;
          w_mm    = '0;
          w_found = 1'b0;
          w_first = '0;
        end
      end
      StSweep: begin
        if (abort) begin
          w_state = StIdle;
        end else begin
          if (a_out) begin
            w_ones = r_ones + CntOne;
          end
          if (a_out != b_out) begin
            w_mm = r_mm + CntOne;
            if (!r_found) begin
              w_found = 1'b1;
              w_first = r_vec;
            end
          end
          // last minterm holds vec so the final value stays visible
          if (r_vec == VecLast) begin
            w_state = StDone;
          end else begin
            w_vec = r_vec + VecOne;
          end
        end
      end
      StDone: begin
        w_state = StIdle;
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  assign vec            = r_vec;
  assign busy           = (r_state != StIdle);
  assign done           = (r_state == StDone);
  assign ones_count     = r_ones;
  assign mismatch_count = r_mm;
  assign mismatch_found = r_found;
  assign first_mismatch = r_first;

endmodule

// File: tb/tb_lab3b_sweep_ctrl.sv
// Directed bench for lab3b_sweep_ctrl: selectable A/B stimulus models driven from vec,
// immediate-assertion checks at each step.
module tb_lab3b_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       a_out;
  logic       b_out;
  logic [8:0] vec;
  logic       busy;
  logic       done;
  logic [9:0] ones_count;
  logic [9:0] mismatch_count;
  logic       mismatch_found;
  logic [8:0] first_mismatch;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  int mode = 0;
  int cyc;
  int first_done;
  int pulses_before;
  int ref_ones;

  lab3b_sweep_ctrl #(
    .N_IN(9)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .a_out         (a_out),
    .b_out         (b_out),
    .vec           (vec),
    .busy          (busy),
    .done          (done),
    .ones_count    (ones_count),
    .mismatch_count(mismatch_count),
    .mismatch_found(mismatch_found),
    .first_mismatch(first_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit 8 is input a, bit 0 is input i
  function automatic logic f_unmin(input logic [8:0] v);
    logic a, b, c, d, e, f, g, h, i;
    {a, b, c, d, e, f, g, h, i} = v;
    return (a & b & c) | (a & b & ~c) | (d & e) | (~d & e & f) | (g & h & i & a) |
           (g & h & i & ~a);
  endfunction

  function automatic logic f_min(input logic [8:0] v);
    logic a, b, c, d, e, f, g, h, i;
    {a, b, c, d, e, f, g, h, i} = v;
    return (a & b) | (e & (d | f)) | (g & h & i);
  endfunction

  always_comb begin
    a_out = 1'b0;
    b_out = 1'b0;
    case (mode)
      0: begin a_out = vec[0];  b_out = vec[0];  end
      1: begin a_out = &vec;    b_out = 1'b0;    end
      2: begin a_out = f_unmin(vec); b_out = f_min(vec); end
      default: begin a_out = vec[0]; b_out = ~vec[0]; end
    endcase
  end

  always @(negedge clk) if (done) done_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // called at posedge+1; start is seen by exactly one edge (E0)
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #2;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_vec", {23'd0, vec}, 0);
    check("rst_ones", {22'd0, ones_count}, 0);
    check("rst_mm", {22'd0, mismatch_count}, 0);
    check("rst_found", {31'd0, mismatch_found}, 0);
    check("rst_first", {23'd0, first_mismatch}, 0);
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: a=b=vec[0]
    mode = 0;
    do_start();
    check("t1_busy_rise", {31'd0, busy}, 1);
    check("t1_vec0", {23'd0, vec}, 0);
    wait_done(600, cyc);
    check("t1_latency", cyc, 512);
    check("t1_ones", {22'd0, ones_count}, 256);
    check("t1_mm", {22'd0, mismatch_count}, 0);
    check("t1_found", {31'd0, mismatch_found}, 0);
    check("t1_vec", {23'd0, vec}, 511);
    @(posedge clk);
    #1;
    check("t1_busy_fall", {31'd0, busy}, 0);
    check("t1_done_fall", {31'd0, done}, 0);

    // 2: a=AND(vec), b=0
    mode = 1;
    do_start();
    check("t2_counts_cleared", {22'd0, ones_count}, 0);
    wait_done(600, cyc);
    check("t2_latency", cyc, 512);
    check("t2_ones", {22'd0, ones_count}, 1);
    check("t2_mm", {22'd0, mismatch_count}, 1);
    check("t2_first", {23'd0, first_mismatch}, 511);
    check("t2_found", {31'd0, mismatch_found}, 1);
    @(posedge clk);
    #1;

    // 3: unminimized vs minimized function
    ref_ones = 0;
    for (int k = 0; k < 512; k++) begin
      logic [8:0] v;
      v = k[8:0];
      if (f_unmin(v)) ref_ones++;
    end
    mode = 2;
    do_start();
    wait_done(600, cyc);
    check("t3_latency", cyc, 512);
    check("t3_mm", {22'd0, mismatch_count}, 0);
    check("t3_found", {31'd0, mismatch_found}, 0);
    check("t3_ones", {22'd0, ones_count}, ref_ones);
    @(posedge clk);
    #1;

    // 4: b=~a, abort at E11
    mode = 3;
    pulses_before = done_pulses;
    do_start();
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("t4_busy", {31'd0, busy}, 0);
    check("t4_done", {31'd0, done}, 0);
    check("t4_mm", {22'd0, mismatch_count}, 10);
    check("t4_ones", {22'd0, ones_count}, 5);
    check("t4_first", {23'd0, first_mismatch}, 0);
    check("t4_found", {31'd0, mismatch_found}, 1);
    check("t4_vec", {23'd0, vec}, 10);
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_done", done_pulses - pulses_before, 0);

    // 5: start pulses during a sweep are ignored
    mode = 0;
    pulses_before = done_pulses;
    first_done = 0;
    do_start();
    for (int c = 1; c <= 520; c++) begin
      start = (c == 100 || c == 512);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done && first_done == 0) first_done = c;
    end
    check("t5_done_edge", first_done, 512);
    check("t5_done_once", done_pulses - pulses_before, 1);
    check("t5_ones", {22'd0, ones_count}, 256);
    check("t5_idle", {31'd0, busy}, 0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("t5_start_abort_idle", {31'd0, busy}, 0);
    check("t5_start_abort_vec", {23'd0, vec}, 511);
    check("t5_start_abort_ones", {22'd0, ones_count}, 256);

    // 6: asynchronous reset mid-sweep
    mode = 3;
    pulses_before = done_pulses;
    do_start();
    repeat (300) @(posedge clk);
    #3;
    check("t6_pre_found", {31'd0, mismatch_found}, 1);
    rst = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_vec", {23'd0, vec}, 0);
    check("t6_ones", {22'd0, ones_count}, 0);
    check("t6_mm", {22'd0, mismatch_count}, 0);
    check("t6_found", {31'd0, mismatch_found}, 0);
    check("t6_first", {23'd0, first_mismatch}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_no_done", done_pulses - pulses_before, 0);
    check("t6_still_idle", {31'd0, busy}, 0);
    mode = 0;
    do_start();
    wait_done(600, cyc);
    check("t6_latency", cyc, 512);
    check("t6_ones", {22'd0, ones_count}, 256);
    check("t6_mm2", {22'd0, mismatch_count}, 0);
    @(posedge clk);
    #1;
    check("t6_busy_fall", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
